// File: rtl/vga_scan_timer.sv
`default_nettype none
// ============================================================================
//  Module   : vga_scan_timer
//  Purpose  : VGA display-timing source. Derives a pixel enable from the
//             system clock, generates DrawX/DrawY scan coordinates for the
//             colour-mapping logic, samples its colour answer and drives
//             registered, mutually aligned VGA pins to the DAC.
//  Ports    : Clk            system clock (rising edge)
//             Reset_n        asynchronous active-low reset
//             Red_in/Green_in/Blue_in  colour for the current DrawX/DrawY
//             DrawX/DrawY    current scan coordinates (registered)
//             pixel_en       one-Clk strobe, pixel advances at this edge
//             frame_start    one-Clk pulse on the frame-wrap cycle
//             VGA_R/G/B      registered pixel colour
//             VGA_HS/VGA_VS  active-low syncs
//             VGA_BLANK_N    low outside the visible area
//             VGA_SYNC_N     tied low (no sync-on-green)
//  Revision : 1.0 - initial release
// ============================================================================
module vga_scan_timer #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [7:0] Red_in,
    input  logic [7:0] Green_in,
    input  logic [7:0] Blue_in,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       pixel_en,
    output logic       frame_start,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] c_div_last = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       c_h_last   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       c_v_last   = 10'(V_TOTAL - 1);

    // Window bounds are 11 bits wide so a bound of exactly 1024 is
    // representable; counters are zero-extended before comparison.
    localparam logic [10:0] c_h_vis    = 11'(H_VISIBLE);
    localparam logic [10:0] c_hs_begin = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] c_hs_end   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] c_v_vis    = 11'(V_VISIBLE);
    localparam logic [10:0] c_vs_begin = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] c_vs_end   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    // ------------------------------------------------------------------
    // Elaboration-time sanity checks
    // ------------------------------------------------------------------
    generate
        if (H_TOTAL > 1024) begin : g_chk_h_total
            $error("vga_scan_timer: H_TOTAL exceeds 10-bit counter range");
        end
        if (V_TOTAL > 1024) begin : g_chk_v_total
            $error("vga_scan_timer: V_TOTAL exceeds 10-bit counter range");
        end
        if (CLK_DIV < 1) begin : g_chk_clk_div
            $error("vga_scan_timer: CLK_DIV must be at least 1");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Pixel-rate divider
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_q, div_d;
    logic             w_pix_en;

    always_comb begin
        div_d = div_q;
        if (div_q == c_div_last) begin
            div_d = '0;
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    generate
        if (CLK_DIV == 1) begin : g_div_one
            // Every clock is a pixel; the strobe is only low while reset is
            // held, so it tracks the reset pin directly.
            assign w_pix_en = Reset_n;
        end else begin : g_div_n
            assign w_pix_en = (div_q == c_div_last);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Scan counters
    // ------------------------------------------------------------------
    logic [9:0] hc_q, hc_d;
    logic [9:0] vc_q, vc_d;
    logic       w_line_end;
    logic       w_frame_end;

    assign w_line_end  = (hc_q == c_h_last);
    assign w_frame_end = w_line_end && (vc_q == c_v_last);

    always_comb begin
        hc_d = hc_q;
        vc_d = vc_q;
        if (w_pix_en) begin
            if (w_line_end) begin
                hc_d = '0;
                // Vertical wraps on the same edge as horizontal at frame end.
                if (vc_q == c_v_last) begin
                    vc_d = '0;
                end else begin
                    vc_d = vc_q + 10'd1;
                end
            end else begin
                hc_d = hc_q + 10'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Timing decode of the current scan position
    // ------------------------------------------------------------------
    logic [10:0] w_hc_ext;
    logic [10:0] w_vc_ext;
    logic        w_visible;
    logic        w_hs_raw;
    logic        w_vs_raw;

    assign w_hc_ext  = {1'b0, hc_q};
    assign w_vc_ext  = {1'b0, vc_q};
    assign w_visible = (w_hc_ext < c_h_vis) && (w_vc_ext < c_v_vis);
    assign w_hs_raw  = !((w_hc_ext >= c_hs_begin) && (w_hc_ext < c_hs_end));
    assign w_vs_raw  = !((w_vc_ext >= c_vs_begin) && (w_vc_ext < c_vs_end));

    // ------------------------------------------------------------------
    // Output stage: samples the pixel being left on each pixel edge, so all
    // VGA pins lag DrawX/DrawY by exactly one pixel and stay aligned.
    // ------------------------------------------------------------------
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       blank_n_q, blank_n_d;
    logic [7:0] r_q, r_d;
    logic [7:0] g_q, g_d;
    logic [7:0] b_q, b_d;

    always_comb begin
        hs_d      = hs_q;
        vs_d      = vs_q;
        blank_n_d = blank_n_q;
        r_d       = r_q;
        g_d       = g_q;
        b_d       = b_q;
        if (w_pix_en) begin
            hs_d      = w_hs_raw;
            vs_d      = w_vs_raw;
            blank_n_d = w_visible;
            r_d       = w_visible ? Red_in   : 8'h00;
            g_d       = w_visible ? Green_in : 8'h00;
            b_d       = w_visible ? Blue_in  : 8'h00;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            div_q     <= '0;
            hc_q      <= '0;
            vc_q      <= '0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
            r_q       <= 8'h00;
            g_q       <= 8'h00;
            b_q       <= 8'h00;
        end else begin
            div_q     <= div_d;
            hc_q      <= hc_d;
            vc_q      <= vc_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            blank_n_q <= blank_n_d;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign DrawX       = hc_q;
    assign DrawY       = vc_q;
    assign pixel_en    = w_pix_en;
    assign frame_start = w_pix_en && w_frame_end;
    assign VGA_R       = r_q;
    assign VGA_G       = g_q;
    assign VGA_B       = b_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_N = blank_n_q;
    assign VGA_SYNC_N  = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_scan_timer
//  Purpose  : Self-checking bench for vga_scan_timer using a reduced raster
//             (32x19 pixels, CLK_DIV=2) with random colour inputs. A
//             pixel-index reference model predicts every output each cycle;
//             literal expectations pin frame period, sync widths and
//             reset/restart behaviour.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_scan_timer;

    localparam int CD    = 2;
    localparam int HV    = 20;
    localparam int HF    = 3;
    localparam int HS    = 4;
    localparam int HB    = 5;
    localparam int VV    = 12;
    localparam int VF    = 2;
    localparam int VS    = 2;
    localparam int VB    = 3;
    localparam int HT    = HV + HF + HS + HB;   // 32
    localparam int VT    = VV + VF + VS + VB;   // 19
    localparam int FRAME = HT * VT;             // 608 pixels

    logic       Clk     = 1'b0;
    logic       Reset_n = 1'b0;
    logic [7:0] red     = 8'h00;
    logic [7:0] grn     = 8'h00;
    logic [7:0] blu     = 8'h00;

    logic [9:0] DrawX, DrawY;
    logic       pixel_en, frame_start;
    logic [7:0] VGA_R, VGA_G, VGA_B;
    logic       VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;

    vga_scan_timer #(
        .CLK_DIV  (CD),
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .Red_in     (red),
        .Green_in   (grn),
        .Blue_in    (blu),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .pixel_en   (pixel_en),
        .frame_start(frame_start),
        .VGA_R      (VGA_R),
        .VGA_G      (VGA_G),
        .VGA_B      (VGA_B),
        .VGA_HS     (VGA_HS),
        .VGA_VS     (VGA_VS),
        .VGA_BLANK_N(VGA_BLANK_N),
        .VGA_SYNC_N (VGA_SYNC_N)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at t=%0t", name, got, want, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Random colour stimulus, changed mid-cycle every clock
    // ------------------------------------------------------------------
    initial begin
        forever begin
            @(negedge Clk);
            #1;
            red = 8'($urandom);
            grn = 8'($urandom);
            blu = 8'($urandom);
        end
    end

    // ------------------------------------------------------------------
    // Reference model: k = rising edges since reset release. The pixel index
    // shown on DrawX/DrawY is floor(k/CD) mod FRAME. On each edge where a
    // pixel ends, remember which pixel it was and the colour presented.
    // ------------------------------------------------------------------
    int          k         = 0;
    bit          smp_valid = 1'b0;
    int          smp_p     = 0;
    logic [23:0] smp_col   = 24'h0;

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            k         <= 0;
            smp_valid <= 1'b0;
        end else begin
            if ((k % CD) == CD - 1) begin
                smp_valid <= 1'b1;
                smp_p     <= (k / CD) % FRAME;
                smp_col   <= {red, grn, blu};
            end
            k <= k + 1;
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle comparison against the model
    // ------------------------------------------------------------------
    bit          chk_en = 1'b0;
    int          m_p, m_hc, m_vc, m_sh, m_sv;
    bit          m_pen, m_fs, m_vis, m_hs, m_vs;
    logic [23:0] m_rgb;

    always @(negedge Clk) begin
        if (chk_en) begin
            if (!Reset_n) begin
                m_hc = 0; m_vc = 0; m_pen = 0; m_fs = 0;
                m_hs = 1; m_vs = 1; m_vis = 0; m_rgb = 24'h0;
            end else begin
                m_p   = (k / CD) % FRAME;
                m_hc  = m_p % HT;
                m_vc  = m_p / HT;
                m_pen = ((k % CD) == CD - 1);
                m_fs  = m_pen && (m_p == FRAME - 1);
                if (!smp_valid) begin
                    m_hs = 1; m_vs = 1; m_vis = 0; m_rgb = 24'h0;
                end else begin
                    m_sh  = smp_p % HT;
                    m_sv  = smp_p / HT;
                    m_vis = (m_sh < HV) && (m_sv < VV);
                    m_hs  = !((m_sh >= HV + HF) && (m_sh < HV + HF + HS));
                    m_vs  = !((m_sv >= VV + VF) && (m_sv < VV + VF + VS));
                    m_rgb = m_vis ? smp_col : 24'h0;
                end
            end
            check("coords", {12'h0, DrawX, DrawY}, {12'h0, 10'(m_hc), 10'(m_vc)});
            check("strobes", {30'h0, pixel_en, frame_start}, {30'h0, m_pen, m_fs});
            check("sync_blank", {28'h0, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N},
                  {28'h0, m_hs, m_vs, m_vis, 1'b0});
            check("rgb", {8'h0, VGA_R, VGA_G, VGA_B}, {8'h0, m_rgb});
        end
    end

    // ------------------------------------------------------------------
    // Directed literal checks
    // ------------------------------------------------------------------
    task automatic check_reset_values(input string tag);
        check({tag, "_drawx"},   DrawX,       0);
        check({tag, "_drawy"},   DrawY,       0);
        check({tag, "_pix_en"},  pixel_en,    0);
        check({tag, "_fstart"},  frame_start, 0);
        check({tag, "_hs"},      VGA_HS,      1);
        check({tag, "_vs"},      VGA_VS,      1);
        check({tag, "_blank_n"}, VGA_BLANK_N, 0);
        check({tag, "_rgb"},     {8'h0, VGA_R, VGA_G, VGA_B}, 0);
        check({tag, "_sync_n"},  VGA_SYNC_N,  0);
    endtask

    // Called just after release: strobe during cycle after edge 1, pixel
    // advances at edge 2.
    task automatic check_first_pixel(input string tag);
        @(negedge Clk);
        check({tag, "_pen1"}, pixel_en, 1);
        check({tag, "_x1"},   DrawX,    0);
        @(negedge Clk);
        check({tag, "_pen2"}, pixel_en, 0);
        check({tag, "_x2"},   DrawX,    1);
        check({tag, "_y2"},   DrawY,    0);
    endtask

    initial begin
        int  n, hs_lo, vs_lo, bl_hi;
        bit  found;

        chk_en  = 1'b1;
        Reset_n = 1'b0;
        repeat (5) @(negedge Clk);
        check_reset_values("por");
        #2 Reset_n = 1'b1;
        check_first_pixel("start");

        // Align to a frame_start pulse.
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge Clk);
            if (frame_start) begin
                found = 1'b1;
                break;
            end
        end
        check("fs_first_seen", found, 1);

        // One full frame period: wrap coordinates, period, sync/blank duty.
        n = 0; hs_lo = 0; vs_lo = 0; bl_hi = 0;
        for (int i = 1; i <= 3000; i++) begin
            @(negedge Clk);
            if (i == 1) begin
                check("wrap_x", DrawX, 0);
                check("wrap_y", DrawY, 0);
                check("fs_width", frame_start, 0);
            end
            if (!VGA_HS)     hs_lo++;
            if (!VGA_VS)     vs_lo++;
            if (VGA_BLANK_N) bl_hi++;
            if (frame_start) begin
                n = i;
                break;
            end
        end
        check("frame_period_clk", n,     1216);  // 608 pixels * 2 clocks
        check("hs_low_clk",       hs_lo, 152);   // 4 px * 19 lines * 2
        check("vs_low_clk",       vs_lo, 128);   // 2 lines * 32 px * 2
        check("blank_hi_clk",     bl_hi, 480);   // 20 * 12 px * 2

        repeat (400) @(negedge Clk);

        // Asynchronous reset in the middle of a frame.
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge Clk);
            if (DrawX == 10'd10 && DrawY == 10'd5) begin
                found = 1'b1;
                break;
            end
        end
        check("midframe_seen", found, 1);
        #2 Reset_n = 1'b0;
        #1 check_reset_values("async");
        repeat (3) @(negedge Clk);
        #2 Reset_n = 1'b1;
        check_first_pixel("restart");

        repeat (1500) @(negedge Clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
